// File: rtl/exe_stage_pkg.sv
// -----------------------------------------------------------------------------
// defines
// Shared widths and types for the execute stage.
//   N                 : datapath width
//   REG_FILE_ADDR_LEN : register address width
//   execmd_t          : ALU operation selector carried in the ID/EXE register
//   mul_state_t       : state of the iterative multiplier (EXE_MUL_EN builds)
// -----------------------------------------------------------------------------
package defines;

  localparam int N                 = 32;
  localparam int REG_FILE_ADDR_LEN = 5;

  typedef enum logic [3:0] {
    EXE_NOP = 4'd0,
    EXE_ADD = 4'd1,
    EXE_SUB = 4'd2,
    EXE_AND = 4'd3,
    EXE_OR  = 4'd4,
    EXE_XOR = 4'd5,
    EXE_SLL = 4'd6,
    EXE_SRL = 4'd7,
    EXE_SRA = 4'd8,
    EXE_SLT = 4'd9,
    EXE_MUL = 4'd10
  } execmd_t;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/exe_stage_forward_mux.sv
// -----------------------------------------------------------------------------
// forward_mux
// Priority operand select for one execute-stage operand. The instruction in MEM
// is younger than the one in WB, so a MEM hit wins. Register 0 is hard-wired
// to zero and therefore never forwarded.
// Ports:
//   i_src                      : source register address of the operand
//   i_id_val                   : value read in decode (ID/EXE register)
//   i_mem_wb_en/_dest/_result  : writeback tuple of the instruction in MEM
//   i_wb_wb_en/_dest/_value    : writeback tuple of the instruction in WB
//   o_val                      : operand value to use in execute
// -----------------------------------------------------------------------------
module forward_mux
  import defines::*;
(
  input  logic [REG_FILE_ADDR_LEN-1:0] i_src,
  input  logic [N-1:0]                 i_id_val,
  input  logic                         i_mem_wb_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] i_mem_dest,
  input  logic [N-1:0]                 i_mem_result,
  input  logic                         i_wb_wb_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] i_wb_dest,
  input  logic [N-1:0]                 i_wb_value,
  output logic [N-1:0]                 o_val
);

  logic w_src_nonzero;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_src_nonzero = (i_src != '0);
  assign w_mem_hit     = i_mem_wb_en && (i_mem_dest == i_src) && w_src_nonzero;
  assign w_wb_hit      = i_wb_wb_en  && (i_wb_dest  == i_src) && w_src_nonzero;

  assign o_val = w_mem_hit ? i_mem_result :
                 w_wb_hit  ? i_wb_value   :
                             i_id_val;

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage of the 5-stage pipeline. Forwards operands from MEM/WB,
// computes the ALU result and registers it with the control bits into the
// EXE/MEM boundary that the MEM stage reads directly.
//
// Build option: define EXE_MUL_EN to compile in the iterative radix-2
// multiplier (N+1 edge latency, stalls upstream). Without it EXE_MUL behaves
// as a NOP that never writes back, and stall is tied low.
//
// Ports:
//   clk, rstn                       : clock, asynchronous active-low reset
//   val1_in, val2_in, st_value_in   : operands / store data from ID/EXE
//   val2_is_reg                     : val2_in came from register src2
//   exe_cmd_in                      : operation
//   mem_r_en_in, mem_w_en_in, wb_en_in, dest_in : control from ID/EXE
//   src1_in, src2_in                : source register addresses
//   mem_wb_en, mem_dest, mem_result : instruction currently in MEM
//   wb_wb_en, wb_dest, wb_value     : instruction currently in WB
//   flush                           : kill the instruction in EXE
//   stall                           : combinational, freezes PC, IF/ID, ID/EXE
//   alu_result, st_value, dest, mem_r_en, mem_w_en, wb_en : EXE/MEM register
// -----------------------------------------------------------------------------
module exe_stage
  import defines::*;
(
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N-1:0]                 val1_in,
  input  logic [N-1:0]                 val2_in,
  input  logic [N-1:0]                 st_value_in,
  input  logic                         val2_is_reg,
  input  execmd_t                      exe_cmd_in,
  input  logic                         mem_r_en_in,
  input  logic                         mem_w_en_in,
  input  logic                         wb_en_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2_in,
  input  logic                         mem_wb_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
  input  logic [N-1:0]                 mem_result,
  input  logic                         wb_wb_en,
  input  logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
  input  logic [N-1:0]                 wb_value,
  input  logic                         flush,
  output logic                         stall,
  output logic [N-1:0]                 alu_result,
  output logic [N-1:0]                 st_value,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic                         mem_r_en,
  output logic                         mem_w_en,
  output logic                         wb_en
);

  localparam int SHAMT_W = $clog2(N);

  // ---------------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------------
  logic [N-1:0]                 w_val1;
  logic [N-1:0]                 w_val2;
  logic [N-1:0]                 w_st_val;
  logic [REG_FILE_ADDR_LEN-1:0] w_val2_src;

  // An immediate val2 must never be replaced; steering its source to r0
  // disables the hit logic without a separate bypass mux.
  assign w_val2_src = val2_is_reg ? src2_in : '0;

  forward_mux u_fwd_val1 (
    .i_src        (src1_in),
    .i_id_val     (val1_in),
    .i_mem_wb_en  (mem_wb_en),
    .i_mem_dest   (mem_dest),
    .i_mem_result (mem_result),
    .i_wb_wb_en   (wb_wb_en),
    .i_wb_dest    (wb_dest),
    .i_wb_value   (wb_value),
    .o_val        (w_val1)
  );

  forward_mux u_fwd_val2 (
    .i_src        (w_val2_src),
    .i_id_val     (val2_in),
    .i_mem_wb_en  (mem_wb_en),
    .i_mem_dest   (mem_dest),
    .i_mem_result (mem_result),
    .i_wb_wb_en   (wb_wb_en),
    .i_wb_dest    (wb_dest),
    .i_wb_value   (wb_value),
    .o_val        (w_val2)
  );

  // Store data always comes from register src2, independent of val2_is_reg.
  forward_mux u_fwd_st (
    .i_src        (src2_in),
    .i_id_val     (st_value_in),
    .i_mem_wb_en  (mem_wb_en),
    .i_mem_dest   (mem_dest),
    .i_mem_result (mem_result),
    .i_wb_wb_en   (wb_wb_en),
    .i_wb_dest    (wb_dest),
    .i_wb_value   (wb_value),
    .o_val        (w_st_val)
  );

  // ---------------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------------
  logic [N-1:0]       w_alu;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt = w_val2[SHAMT_W-1:0];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_alu = '0;
    case (exe_cmd_in)
      EXE_ADD: w_alu = w_val1 + w_val2;
      EXE_SUB: w_alu = w_val1 - w_val2;
      EXE_AND: w_alu = w_val1 & w_val2;
      EXE_OR:  w_alu = w_val1 | w_val2;
      EXE_XOR: w_alu = w_val1 ^ w_val2;
      EXE_SLL: w_alu = w_val1 << w_shamt;
      EXE_SRL: w_alu = w_val1 >> w_shamt;
      EXE_SRA: w_alu = $signed(w_val1) >>> w_shamt;
      EXE_SLT: w_alu = {{(N-1){1'b0}}, ($signed(w_val1) < $signed(w_val2))};
      default: w_alu = '0;   // EXE_NOP, and EXE_MUL outside BUSY
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result select and stall
  // ---------------------------------------------------------------------------
  logic [N-1:0] w_result;
  logic         w_wb_en_eff;
  logic         w_bubble;

`ifdef EXE_MUL_EN
  localparam int CNT_W = $clog2(N);

  mul_state_t     r_state;
  mul_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]   r_mcand;    // multiplicand, shifted left each step
  logic [N-1:0]   r_mplier;   // multiplier, shifted right each step
  logic [N-1:0]   r_acc;      // partial product, low N bits only
  logic [N-1:0]   w_step_sum;
  logic           w_mul_start;
  logic           w_mul_last;
  logic           w_stall_raw;

  // The Nth partial-product add happens combinationally in the final BUSY
  // cycle and goes straight into alu_result, so only N-1 steps are stored.
  assign w_step_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_state == MUL_BUSY) && (r_cnt == CNT_W'(N-1));

  always_comb begin
    w_state_nxt = r_state;
    w_stall_raw = 1'b0;
    w_mul_start = 1'b0;
    case (r_state)
      MUL_IDLE: begin
        if ((exe_cmd_in == EXE_MUL) && !flush) begin
          w_state_nxt = MUL_BUSY;
          w_stall_raw = 1'b1;
          w_mul_start = 1'b1;
        end
      end
      MUL_BUSY: begin
        // A flush aborts; stall drops in the same cycle so the bubble loads.
        if (flush || w_mul_last) begin
          w_state_nxt = MUL_IDLE;
        end else begin
          w_stall_raw = 1'b1;
        end
      end
      default: w_state_nxt = MUL_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= MUL_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_mul_start) begin
        // Operands are captured once; forwarding changes during BUSY are ignored.
        r_mcand  <= w_val1;
        r_mplier <= w_val2;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == MUL_BUSY) begin
        r_acc    <= w_step_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  // The FSM is forced idle during reset, but an EXE_MUL sitting in ID/EXE
  // would still decode as a start; gating keeps stall low while rstn is low.
  assign stall       = w_stall_raw & rstn;
  assign w_result    = (r_state == MUL_BUSY) ? w_step_sum : w_alu;
  assign w_wb_en_eff = wb_en_in;
`else
  assign stall       = 1'b0;
  assign w_result    = w_alu;
  // Without the multiplier an EXE_MUL must not corrupt its destination.
  assign w_wb_en_eff = wb_en_in & (exe_cmd_in != EXE_MUL);
`endif

  assign w_bubble = stall | flush;

  // ---------------------------------------------------------------------------
  // EXE/MEM pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_result <= '0;
      st_value   <= '0;
      dest       <= '0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      wb_en      <= 1'b0;
    end else if (w_bubble) begin
      // Only the enables matter for a bubble; data is zeroed for clean traces.
      alu_result <= '0;
      st_value   <= '0;
      dest       <= '0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      wb_en      <= 1'b0;
    end else begin
      alu_result <= w_result;
      st_value   <= w_st_val;
      dest       <= dest_in;
      mem_r_en   <= mem_r_en_in;
      mem_w_en   <= mem_w_en_in;
      wb_en      <= w_wb_en_eff;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
// Directed, table-driven bench for exe_stage plus hand-written sequences for
// the multi-cycle multiply, flush and asynchronous reset cases. Multiply
// sequences are compiled when EXE_MUL_EN is defined; otherwise the bench
// checks that EXE_MUL is a non-writing NOP that never stalls.
// -----------------------------------------------------------------------------
module tb_exe_stage;
  import defines::*;

  logic          clk;
  logic          rstn;
  logic [31:0]   val1_in, val2_in, st_value_in;
  logic          val2_is_reg;
  execmd_t       exe_cmd_in;
  logic          mem_r_en_in, mem_w_en_in, wb_en_in;
  logic [4:0]    dest_in, src1_in, src2_in;
  logic          mem_wb_en;
  logic [4:0]    mem_dest;
  logic [31:0]   mem_result;
  logic          wb_wb_en;
  logic [4:0]    wb_dest;
  logic [31:0]   wb_value;
  logic          flush;
  logic          stall;
  logic [31:0]   alu_result, st_value;
  logic [4:0]    dest;
  logic          mem_r_en, mem_w_en, wb_en;

  int checks = 0;
  int errors = 0;

  exe_stage dut (
    .clk         (clk),
    .rstn        (rstn),
    .val1_in     (val1_in),
    .val2_in     (val2_in),
    .st_value_in (st_value_in),
    .val2_is_reg (val2_is_reg),
    .exe_cmd_in  (exe_cmd_in),
    .mem_r_en_in (mem_r_en_in),
    .mem_w_en_in (mem_w_en_in),
    .wb_en_in    (wb_en_in),
    .dest_in     (dest_in),
    .src1_in     (src1_in),
    .src2_in     (src2_in),
    .mem_wb_en   (mem_wb_en),
    .mem_dest    (mem_dest),
    .mem_result  (mem_result),
    .wb_wb_en    (wb_wb_en),
    .wb_dest     (wb_dest),
    .wb_value    (wb_value),
    .flush       (flush),
    .stall       (stall),
    .alu_result  (alu_result),
    .st_value    (st_value),
    .dest        (dest),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .wb_en       (wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    execmd_t     cmd;
    logic [31:0] v1, v2, st;
    logic        v2reg;
    logic [4:0]  s1, s2, d;
    logic        mwb;
    logic [4:0]  md;
    logic [31:0] mr;
    logic        wwb;
    logic [4:0]  wd;
    logic [31:0] wv;
    logic        rin, win, wbin, fl;
    logic [31:0] e_alu, e_st;
    logic [4:0]  e_dest;
    logic        e_wb, e_r, e_w;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    exe_cmd_in = EXE_NOP; val1_in = '0; val2_in = '0; st_value_in = '0;
    val2_is_reg = 1'b0; src1_in = '0; src2_in = '0; dest_in = '0;
    mem_wb_en = 1'b0; mem_dest = '0; mem_result = '0;
    wb_wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; wb_en_in = 1'b0; flush = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    exe_cmd_in = v.cmd; val1_in = v.v1; val2_in = v.v2; st_value_in = v.st;
    val2_is_reg = v.v2reg; src1_in = v.s1; src2_in = v.s2; dest_in = v.d;
    mem_wb_en = v.mwb; mem_dest = v.md; mem_result = v.mr;
    wb_wb_en = v.wwb; wb_dest = v.wd; wb_value = v.wv;
    mem_r_en_in = v.rin; mem_w_en_in = v.win; wb_en_in = v.wbin; flush = v.fl;
  endtask

  task automatic check_ctrl(input string name, input logic [4:0] e_d, input logic e_wb, input logic e_r, input logic e_w);
    check(name, 64'({dest, wb_en, mem_r_en, mem_w_en}), 64'({e_d, e_wb, e_r, e_w}));
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fields: name, cmd, v1, v2, st, v2reg, s1, s2, d, mwb, md, mr, wwb, wd, wv,
    //         rin, win, wbin, fl, e_alu, e_st, e_dest, e_wb, e_r, e_w
    vecs.push_back('{"add",       EXE_ADD, 32'd7,          32'd5,          32'd0,  1'b0, 5'd0, 5'd0, 5'd3,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd12,         32'h0,  5'd3,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"sub_wrap",  EXE_SUB, 32'd0,          32'd1,          32'd0,  1'b0, 5'd0, 5'd0, 5'd1,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF,  32'h0,  5'd1,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"and",       EXE_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'd0,  1'b0, 5'd0, 5'd0, 5'd2,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hF000_F000,  32'h0,  5'd2,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"or",        EXE_OR,  32'h0000_0F00,  32'h0000_00F0,  32'd0,  1'b0, 5'd0, 5'd0, 5'd2,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0FF0,  32'h0,  5'd2,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"xor",       EXE_XOR, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'd0,  1'b0, 5'd0, 5'd0, 5'd2,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hF0F0_0F0F,  32'h0,  5'd2,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"sll_mask",  EXE_SLL, 32'd1,          32'h0000_003F,  32'd0,  1'b0, 5'd0, 5'd0, 5'd2,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000,  32'h0,  5'd2,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"srl",       EXE_SRL, 32'h8000_0000,  32'd4,          32'd0,  1'b0, 5'd0, 5'd0, 5'd2,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0800_0000,  32'h0,  5'd2,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"sra",       EXE_SRA, 32'h8000_0000,  32'd4,          32'd0,  1'b0, 5'd0, 5'd0, 5'd2,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'hF800_0000,  32'h0,  5'd2,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"slt_neg",   EXE_SLT, 32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0, 5'd0, 5'd0, 5'd2,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd1,          32'h0,  5'd2,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"slt_pos",   EXE_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0, 5'd0, 5'd0, 5'd2,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0,          32'h0,  5'd2,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"nop",       EXE_NOP, 32'd5,          32'd6,          32'd0,  1'b0, 5'd0, 5'd0, 5'd9,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0,          32'h0,  5'd9,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"fwd_mem",   EXE_SUB, 32'h99,         32'd1,          32'd0,  1'b0, 5'd4, 5'd0, 5'd4,  1'b1, 5'd4, 32'h10, 1'b1, 5'd4, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0F,         32'h0,  5'd4,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"fwd_src0",  EXE_SUB, 32'h99,         32'd1,          32'd0,  1'b0, 5'd0, 5'd0, 5'd4,  1'b1, 5'd0, 32'h10, 1'b1, 5'd0, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h98,         32'h0,  5'd4,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"fwd_wb",    EXE_SUB, 32'h99,         32'd1,          32'd0,  1'b0, 5'd4, 5'd0, 5'd4,  1'b0, 5'd4, 32'h10, 1'b1, 5'd4, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1F,         32'h0,  5'd4,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"fwd_mmiss", EXE_SUB, 32'h99,         32'd1,          32'd0,  1'b0, 5'd4, 5'd0, 5'd4,  1'b1, 5'd5, 32'h10, 1'b1, 5'd4, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1F,         32'h0,  5'd4,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"st_fwd",    EXE_ADD, 32'd1,          32'd2,          32'h55, 1'b0, 5'd0, 5'd6, 5'd0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'hAB, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3,          32'hAB, 5'd0,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{"v2_fwd",    EXE_ADD, 32'd1,          32'd2,          32'h55, 1'b1, 5'd0, 5'd6, 5'd8,  1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'hAB, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAC,         32'hAB, 5'd8,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"load_ctl",  EXE_ADD, 32'h100,        32'd4,          32'd0,  1'b0, 5'd0, 5'd0, 5'd10, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h104,        32'h0,  5'd10, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"flush",     EXE_ADD, 32'd7,          32'd5,          32'h33, 1'b0, 5'd0, 5'd0, 5'd3,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'd0,          32'h0,  5'd0,  1'b0, 1'b0, 1'b0});

    // ---------------- reset state ----------------
    clear_inputs();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #2;
    check("reset_alu", 64'(alu_result), 64'(32'h0));
    check("reset_st", 64'(st_value), 64'(32'h0));
    check_ctrl("reset_ctrl", 5'd0, 1'b0, 1'b0, 1'b0);
    check("reset_stall", 64'(stall), 64'(1'b0));
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // ---------------- table-driven single-cycle ops ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #1;
      check({vecs[i].name, "_stall"}, 64'(stall), 64'(1'b0));
      tick();
      check({vecs[i].name, "_alu"}, 64'(alu_result), 64'(vecs[i].e_alu));
      check({vecs[i].name, "_st"}, 64'(st_value), 64'(vecs[i].e_st));
      check_ctrl({vecs[i].name, "_ctrl"}, vecs[i].e_dest, vecs[i].e_wb, vecs[i].e_r, vecs[i].e_w);
    end
    clear_inputs();
    tick();

`ifdef EXE_MUL_EN
    begin
      int n_stall;
      logic bubble_ok;
      // ---------------- MUL 0xFFFFFFFF * 3, val1 forwarded from MEM ----------------
      clear_inputs();
      exe_cmd_in = EXE_MUL; val1_in = 32'h0; src1_in = 5'd9;
      mem_wb_en = 1'b1; mem_dest = 5'd9; mem_result = 32'hFFFF_FFFF;
      val2_in = 32'd3; wb_en_in = 1'b1; dest_in = 5'd7;
      #1;
      n_stall = 0;
      bubble_ok = 1'b1;
      while (stall && n_stall < 100) begin
        n_stall++;
        if (n_stall == 3) mem_result = 32'h0;   // BUSY: must not affect the product
        tick();
        if (wb_en !== 1'b0) bubble_ok = 1'b0;
      end
      check("mul_stall_cycles", 64'(n_stall), 64'(32));
      check("mul_bubbles", 64'(bubble_ok), 64'(1'b1));
      tick();
      check("mul_result", 64'(alu_result), 64'(32'hFFFF_FFFD));
      check_ctrl("mul_ctrl", 5'd7, 1'b1, 1'b0, 1'b0);
      clear_inputs();
      tick();

      // ---------------- flush at BUSY cycle 5 ----------------
      exe_cmd_in = EXE_MUL; val1_in = 32'd6; val2_in = 32'd7; wb_en_in = 1'b1; dest_in = 5'd2;
      #1;
      check("flush_mul_stall0", 64'(stall), 64'(1'b1));
      repeat (5) tick();
      flush = 1'b1;
      #1;
      check("flush_stall_drop", 64'(stall), 64'(1'b0));
      tick();
      check_ctrl("flush_bubble", 5'd0, 1'b0, 1'b0, 1'b0);
      clear_inputs();
      exe_cmd_in = EXE_ADD; val1_in = 32'd2; val2_in = 32'd3; wb_en_in = 1'b1; dest_in = 5'd4;
      #1;
      check("flush_add_stall", 64'(stall), 64'(1'b0));
      tick();
      check("flush_add_alu", 64'(alu_result), 64'(32'd5));
      check_ctrl("flush_add_ctrl", 5'd4, 1'b1, 1'b0, 1'b0);
      clear_inputs();
      tick();
    end
`else
    // ---------------- MUL without the multiplier: non-writing NOP ----------------
    begin
      logic stall_seen;
      exe_cmd_in = EXE_MUL; val1_in = 32'hFFFF_FFFF; val2_in = 32'd3; wb_en_in = 1'b1; dest_in = 5'd7;
      stall_seen = 1'b0;
      #1;
      if (stall !== 1'b0) stall_seen = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        if (stall !== 1'b0) stall_seen = 1'b1;
      end
      check("nomul_stall", 64'(stall_seen), 64'(1'b0));
      check("nomul_alu", 64'(alu_result), 64'(32'h0));
      check_ctrl("nomul_ctrl", 5'd7, 1'b0, 1'b0, 1'b0);
      clear_inputs();
      tick();
    end
`endif

    // ---------------- asynchronous reset clears outputs immediately ----------------
    exe_cmd_in = EXE_ADD; val1_in = 32'd10; val2_in = 32'd20; st_value_in = 32'h77;
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; dest_in = 5'd5;
    tick();
    check("pre_rst_alu", 64'(alu_result), 64'(32'd30));
    #2 rstn = 1'b0;
    #1;
    check("async_rst_alu", 64'(alu_result), 64'(32'h0));
    check("async_rst_st", 64'(st_value), 64'(32'h0));
    check_ctrl("async_rst_ctrl", 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    clear_inputs();
    tick();

`ifdef EXE_MUL_EN
    // ---------------- reset pulsed mid-multiply ----------------
    exe_cmd_in = EXE_MUL; val1_in = 32'd9; val2_in = 32'd9; wb_en_in = 1'b1; dest_in = 5'd3;
    repeat (4) tick();
    check("midmul_busy_stall", 64'(stall), 64'(1'b1));
    #2 rstn = 1'b0;
    #1;
    check("midmul_rst_stall", 64'(stall), 64'(1'b0));
    check_ctrl("midmul_rst_ctrl", 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    clear_inputs();
    exe_cmd_in = EXE_ADD; val1_in = 32'd2; val2_in = 32'd2; wb_en_in = 1'b1; dest_in = 5'd6;
    #1;
    check("post_rst_stall", 64'(stall), 64'(1'b0));
    tick();
    check("post_rst_alu", 64'(alu_result), 64'(32'd4));
    check_ctrl("post_rst_ctrl", 5'd6, 1'b1, 1'b0, 1'b0);
`else
    exe_cmd_in = EXE_ADD; val1_in = 32'd2; val2_in = 32'd2; wb_en_in = 1'b1; dest_in = 5'd6;
    tick();
    check("post_rst_alu", 64'(alu_result), 64'(32'd4));
    check_ctrl("post_rst_ctrl", 5'd6, 1'b1, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
